ball_step_integrator: RTL and testbench
=======================================

// Module: ball_step_integrator
// PURPOSE
//  Per-ball state holder and time-step integrator for the billiard physics path; sits directly upstream of
//  rectify_p_v. On each step request it advances position by velocity*dt, applies friction decay to velocity,
//  then presents {p,v} to the rectify stage. Rectified values come back through the load port.
// PARAMETERS
//  N            32  width of every position/velocity word, signed two's complement fixed point
//  DT_SHIFT      4  dt = 2^-DT_SHIFT; position increment = v >>> DT_SHIFT
//  FRIC_SHIFT    6  friction: v_next = v - (v >>> FRIC_SHIFT)
//  STOP_THRESH  16  per-axis |v| below this after friction is forced to 0 (positive, < 2^(N-1))
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  reset, synchronous, active-high
//  load_valid   in   1  request to overwrite ball state with load_* values
//  load_ready   out  1  high only in IDLE
//  load_p_x/y   in   N  signed position to load
//  load_v_x/y   in   N  signed velocity to load
//  step_valid   in   1  request one integration step
//  step_ready   out  1  high in IDLE when load_valid is low
//  out_valid    out  1  {p,v} result valid for downstream rectify stage
//  out_ready    in   1  downstream accepts result
//  p_x, p_y     out  N  current position registers
//  v_x, v_y     out  N  current velocity registers
//  moving       out  1  combinational: (v_x != 0) | (v_y != 0)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; p_x,p_y,v_x,v_y=0; out_valid=0; load_ready=1, step_ready=1 after.
//   Reset in any state (incl. mid-step or OUT with pending result) aborts and discards the step.
//  FSM states: IDLE, INTEG, FRIC, OUT.
//  IDLE: load_valid=1 -> registers take load_* at the edge, stay IDLE (load has priority; simultaneous step
//   is not accepted, step_ready=0 that cycle). Else step_valid=1 -> accepted, next state INTEG.
//  INTEG (1 cycle): p_x += v_x >>> DT_SHIFT, p_y += v_y >>> DT_SHIFT (arithmetic shift, N-bit add,
//   silent two's-complement wrap, no saturation); v unchanged; next FRIC.
//  FRIC (1 cycle): t = v - (v >>> FRIC_SHIFT) per axis; if -STOP_THRESH < t < STOP_THRESH then v=0 else v=t
//   (threshold required: arithmetic shift of small negatives never decays to 0); next OUT.
//  OUT: out_valid=1; p,v held stable; load/step not ready; out_ready=1 -> IDLE, out_valid=0 next cycle.
//   out_ready ignored outside OUT.
//  Latency: step accepted at edge E0 -> out_valid high after edge E2 (3rd cycle from acceptance);
//   minimum step-to-step period 4 cycles with out_ready tied high.
//  Outputs p,v are register values in every state; only consider them meaningful while out_valid=1
//   or in IDLE. load_ready/step_ready/out_valid are decoded from state only (no comb path from *_valid
//   to *_ready except step_ready's dependence on load_valid).
//  Zero velocity: step still runs full sequence; p,v unchanged; moving=0.
// TESTING (N=32, DT_SHIFT=4, FRIC_SHIFT=6, STOP_THRESH=16)
//  1 Load p=(0x0010_0000,0x0020_0000) v=(0x0001_0000,-0x0001_0000), step, out_ready=1 -> out_valid 3 cycles
//    after accept; p=(0x0010_1000,0x001F_F000), v=(0x0000_FC00,-0x0000_FC00), moving=1.
//  2 Load v=(15,-10), p=0, step -> v=(0,0) (15->15<16; -10->-9 >-16), p=(0,-1), moving=0.
//  3 Step with out_ready=0 for 5 cycles, step_valid/load_valid pulsed meanwhile -> out_valid stays 1,
//    p,v stable, both readys 0; out_ready=1 -> IDLE next cycle, no extra step executed.
//  4 In IDLE drive load_valid=1 and step_valid=1 together -> load taken, step_ready=0, state stays IDLE.
//  5 Assert rst during INTEG -> next cycle IDLE, p=v=0, out_valid=0, step_ready=1; no out_valid pulse.
//  6 Load p_x=0x7FFF_FFFF v_x=0x10, step -> p_x=0x8000_0000 (wrap), v_x=0x10.

Source files
------------

// File: rtl/ball_step_integrator.sv
// Per-ball position/velocity holder: on a step request integrates p += v*dt, applies friction
// decay with a stop threshold, then presents {p,v} to the downstream rectify stage.
module ball_step_integrator #(
    parameter int unsigned N           = 32,
    parameter int unsigned DT_SHIFT    = 4,
    parameter int unsigned FRIC_SHIFT  = 6,
    parameter int unsigned STOP_THRESH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_p_x,
    input  logic [N-1:0] load_p_y,
    input  logic [N-1:0] load_v_x,
    input  logic [N-1:0] load_v_y,
    input  logic         step_valid,
    output logic         step_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] p_x,
    output logic [N-1:0] p_y,
    output logic [N-1:0] v_x,
    output logic [N-1:0] v_y,
    output logic         moving
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        FRIC  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic signed [N-1:0] THRESH_POS = N'(STOP_THRESH);
    localparam logic signed [N-1:0] THRESH_NEG = -THRESH_POS;

    state_t state_q, state_d;

    logic signed [N-1:0] p_x_q, p_y_q, v_x_q, v_y_q;
    logic signed [N-1:0] p_x_d, p_y_d, v_x_d, v_y_d;
    logic signed [N-1:0] fric_x, fric_y;

    // State and ball registers; reset discards any step in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_x_q   <= '0;
            p_y_q   <= '0;
            v_x_q   <= '0;
            v_y_q   <= '0;
        end else begin
            state_q <= state_d;
            p_x_q   <= p_x_d;
            p_y_q   <= p_y_d;
            v_x_q   <= v_x_d;
            v_y_q   <= v_y_d;
        end
    end

    // Friction decay; arithmetic shift never reaches zero for small negatives, hence the threshold.
    always_comb begin
        fric_x = v_x_q - (v_x_q >>> FRIC_SHIFT);
        fric_y = v_y_q - (v_y_q >>> FRIC_SHIFT);
        if ((fric_x > THRESH_NEG) && (fric_x < THRESH_POS)) begin
            fric_x = '0;
        end
        if ((fric_y > THRESH_NEG) && (fric_y < THRESH_POS)) begin
            fric_y = '0;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        p_x_d   = p_x_q;
        p_y_d   = p_y_q;
        v_x_d   = v_x_q;
        v_y_d   = v_y_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    p_x_d = load_p_x;
                    p_y_d = load_p_y;
                    v_x_d = load_v_x;
                    v_y_d = load_v_y;
                end else if (step_valid) begin
                    state_d = INTEG;
                end
            end
            INTEG: begin
                p_x_d   = p_x_q + (v_x_q >>> DT_SHIFT);
                p_y_d   = p_y_q + (v_y_q >>> DT_SHIFT);
                state_d = FRIC;
            end
            FRIC: begin
                v_x_d   = fric_x;
                v_y_d   = fric_y;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign step_ready = (state_q == IDLE) && !load_valid;
    assign out_valid  = (state_q == OUT);

    assign p_x    = p_x_q;
    assign p_y    = p_y_q;
    assign v_x    = v_x_q;
    assign v_y    = v_y_q;
    assign moving = (v_x_q != '0) || (v_y_q != '0);

endmodule

// File: tb/tb_ball_step_integrator.sv
// Directed bench for ball_step_integrator with hand-computed expected ball states.
module tb_ball_step_integrator;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_p_x, load_p_y, load_v_x, load_v_y;
    logic        step_valid;
    logic        step_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p_x, p_y, v_x, v_y;
    logic        moving;

    int n_tests = 0;
    int n_fail  = 0;

    ball_step_integrator dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_p_x   (load_p_x),
        .load_p_y   (load_p_y),
        .load_v_x   (load_v_x),
        .load_v_y   (load_v_y),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p_x        (p_x),
        .p_y        (p_y),
        .v_x        (v_x),
        .v_y        (v_y),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] px, input logic [31:0] py,
                           input logic [31:0] vx, input logic [31:0] vy);
        load_p_x   = px;
        load_p_y   = py;
        load_v_x   = vx;
        load_v_y   = vy;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    // Accept a step and wait for out_valid, checking the acceptance-to-valid latency.
    task automatic do_step(input string tag);
        int cycles;
        step_valid = 1'b1;
        #1;
        check_val({tag, "_step_ready"}, 64'(step_ready), 64'd1);
        tick();
        step_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check_val({tag, "_latency"}, 64'(cycles), 64'd2);
    endtask

    task automatic check_ball(input string tag, input logic [31:0] epx, input logic [31:0] epy,
                              input logic [31:0] evx, input logic [31:0] evy, input logic emov);
        check_val({tag, "_p_x"}, 64'(p_x), 64'(epx));
        check_val({tag, "_p_y"}, 64'(p_y), 64'(epy));
        check_val({tag, "_v_x"}, 64'(v_x), 64'(evx));
        check_val({tag, "_v_y"}, 64'(v_y), 64'(evy));
        check_val({tag, "_moving"}, 64'(moving), 64'(emov));
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        step_valid = 1'b0;
        out_ready  = 1'b1;
        load_p_x   = '0;
        load_p_y   = '0;
        load_v_x   = '0;
        load_v_y   = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_load_ready", 64'(load_ready), 64'd1);
        check_val("rst_step_ready", 64'(step_ready), 64'd1);
        check_ball("rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Basic integrate + friction.
        do_load(32'h0010_0000, 32'h0020_0000, 32'h0001_0000, 32'hFFFF_0000);
        do_step("t1");
        check_val("t1_out_valid", 64'(out_valid), 64'd1);
        check_ball("t1", 32'h0010_1000, 32'h001F_F000, 32'h0000_FC00, 32'hFFFF_0400, 1'b1);
        tick();
        check_val("t1_out_done", 64'(out_valid), 64'd0);
        check_val("t1_idle", 64'(load_ready), 64'd1);

        // Small velocities stop under the threshold.
        do_load(32'h0, 32'h0, 32'd15, 32'hFFFF_FFF6);
        do_step("t2");
        check_ball("t2", 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        tick();

        // Backpressure: OUT holds, new requests ignored.
        do_load(32'h0010_0000, 32'h0020_0000, 32'h0001_0000, 32'hFFFF_0000);
        out_ready = 1'b0;
        do_step("t3");
        for (int i = 0; i < 5; i++) begin
            step_valid = i[0];
            load_valid = ~i[0];
            load_p_x   = 32'hDEAD_BEEF;
            load_v_x   = 32'h1234_5678;
            tick();
            check_val("t3_hold_valid", 64'(out_valid), 64'd1);
            check_val("t3_hold_load_ready", 64'(load_ready), 64'd0);
            check_val("t3_hold_step_ready", 64'(step_ready), 64'd0);
        end
        step_valid = 1'b0;
        load_valid = 1'b0;
        check_ball("t3_hold", 32'h0010_1000, 32'h001F_F000, 32'h0000_FC00, 32'hFFFF_0400, 1'b1);
        out_ready = 1'b1;
        tick();
        check_val("t3_release", 64'(out_valid), 64'd0);
        tick();
        tick();
        check_val("t3_no_extra_step", 64'(out_valid), 64'd0);
        check_ball("t3_after", 32'h0010_1000, 32'h001F_F000, 32'h0000_FC00, 32'hFFFF_0400, 1'b1);

        // Load beats a simultaneous step.
        load_p_x   = 32'h0000_0100;
        load_p_y   = 32'h0000_0200;
        load_v_x   = 32'h0000_0300;
        load_v_y   = 32'h0000_0400;
        load_valid = 1'b1;
        step_valid = 1'b1;
        #1;
        check_val("t4_step_ready", 64'(step_ready), 64'd0);
        check_val("t4_load_ready", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        step_valid = 1'b0;
        check_val("t4_idle", 64'(load_ready), 64'd1);
        check_ball("t4", 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 1'b1);
        tick();
        tick();
        check_val("t4_no_step", 64'(out_valid), 64'd0);

        // Reset during INTEG aborts the step.
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_out_valid", 64'(out_valid), 64'd0);
        check_val("t5_step_ready", 64'(step_ready), 64'd1);
        check_ball("t5", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t5_no_pulse", 64'(out_valid), 64'd0);
        end

        // Zero velocity still runs the full sequence.
        do_step("t7");
        check_ball("t7", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        // Position wraps silently.
        do_load(32'h7FFF_FFFF, 32'h0, 32'h0000_0010, 32'h0);
        do_step("t6");
        check_ball("t6", 32'h8000_0000, 32'h0, 32'h0000_0010, 32'h0, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
